led_pattern_seq: RTL and testbench

- Downstream consumer of the LED blink counter's toggling output.
- Every toggle of `tick_in`, either edge, advances an N-bit LED pattern.
- The pattern is one of four selectable modes.
- The pattern is gated by an 8-bit PWM brightness control before driving the board LEDs.
- Lets the board show walking, ping-pong, binary-count or blink patterns at the upstream blink rate.

---
 rtl/led_pattern_seq.sv | 146 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//
// Steps an N-bit LED pattern on every edge of an upstream toggling tick.
// The pattern can walk, ping-pong, binary-count or blink. The result is gated
// by an 8-bit PWM brightness control before it drives the board LEDs.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        asynchronous reset, active-high
//   tick_in    toggling level from the blink counter; each edge is one step
//   mode       pattern select: 0 walk, 1 ping-pong, 2 binary count, 3 blink
//   pause      1 = steps are ignored and the pattern is frozen; PWM keeps running
//   duty       brightness: 0 = off, all ones = fully on
//   led        gated pattern to the pins, active-high
//   step_pulse one-cycle pulse in the cycle the pattern register updates
module led_pattern_seq #(
  parameter int N     = 8,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic [PWM_W-1:0] duty,
  output logic [N-1:0]     led,
  output logic             step_pulse
);

  localparam logic [1:0] MODE_WALK  = 2'd0;
  localparam logic [1:0] MODE_PING  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [N-1:0]     PAT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] PWM_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     pat;
  logic [N-1:0]     pat_next;
  logic             dir;
  logic             dir_next;
  logic [1:0]       mode_r;
  logic             tick_q;
  logic             primed;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_r;
  logic             step;
  logic             en;

  // The first cycle after reset only captures the tick level. That way a
  // tick_in held high through reset is not mistaken for an edge.
  assign step = primed & (tick_in ^ tick_q) & ~pause;

  // Full-scale duty must stay lit on count value all-ones too. A plain
  // compare would leave one dark cycle per period.
  assign en = (&duty_r) | (pwm_cnt < duty_r);

  // Next pattern. A mode change only reloads the new mode's starting
  // pattern; advancing waits for the following step.
  always_comb begin
    pat_next = pat;
    dir_next = dir;
    if (mode != mode_r) begin
      case (mode)
        MODE_WALK:  pat_next = PAT_ONE;
        MODE_PING: begin
          pat_next = PAT_ONE;
          dir_next = 1'b0;
        end
        MODE_COUNT: pat_next = '0;
        default:    pat_next = '1;
      endcase
    end else begin
      case (mode_r)
        MODE_WALK:  pat_next = {pat[N-2:0], pat[N-1]};
        MODE_PING: begin
          // The bounce turns around in the same step that reaches the end,
          // so an end position is never held for two steps.
          if (!dir) begin
            if (pat[N-1]) begin
              dir_next = 1'b1;
              pat_next = pat >> 1;
            end else begin
              pat_next = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              dir_next = 1'b0;
              pat_next = pat << 1;
            end else begin
              pat_next = pat >> 1;
            end
          end
        end
        MODE_COUNT: pat_next = pat + PAT_ONE;
        MODE_BLINK: pat_next = ~pat;
        default:    pat_next = pat;
      endcase
    end
  end

  // Edge detector and pattern state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      primed     <= 1'b0;
      pat        <= PAT_ONE;
      dir        <= 1'b0;
      mode_r     <= MODE_WALK;
      step_pulse <= 1'b0;
    end else begin
      tick_q     <= tick_in;
      primed     <= 1'b1;
      step_pulse <= step;
      if (step) begin
        mode_r <= mode;
        pat    <= pat_next;
        dir    <= dir_next;
      end
    end
  end

  // PWM. Duty is sampled only at the period start, so a change
  // never produces a partial period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
      if (pwm_cnt == '0) begin
        duty_r <= duty;
      end
    end
  end

  // Registered LED output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= pat & {N{en}};
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq
//
// Testbench for led_pattern_seq. Each toggle of tick_in pushes the expected
// pattern into a queue. A monitor pops and compares it against led one cycle
// after step_pulse. PWM behaviour and async reset are checked inline.
module tb_led_pattern_seq;

  localparam int N     = 8;
  localparam int PWM_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_in;
  logic [1:0]       mode;
  logic             pause;
  logic [PWM_W-1:0] duty;
  logic [N-1:0]     led;
  logic             step_pulse;

  int tests      = 0;
  int fails      = 0;
  int step_count = 0;
  bit pending    = 1'b0;
  logic [N-1:0] exp_q [$];

  logic [N-1:0] walk_exp [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [N-1:0] ping_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  led_pattern_seq #(.N(N), .PWM_W(PWM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .mode      (mode),
    .pause     (pause),
    .duty      (duty),
    .led       (led),
    .step_pulse(step_pulse)
  );

  always #10 clk = ~clk;

  // Monitor: a step_pulse means led shows the new pattern one cycle later
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL scoreboard_unexpected_step: got step with led=%h, required no step", led);
        end else begin
          logic [N-1:0] e;
          e = exp_q.pop_front();
          if (led !== e) begin
            fails++;
            $display("[TB] FAIL scoreboard_led: got %h, required %h", led, e);
          end
        end
      end
      if (step_pulse === 1'b1) begin
        step_count++;
        pending = 1'b1;
      end
    end
  end

  task automatic toggle_step(input logic [N-1:0] e, input bit push, input int gap);
    @(posedge clk);
    #1;
    tick_in = ~tick_in;
    if (push) exp_q.push_back(e);
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_steps(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("[TB] FAIL %s_steps: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int base;
    rst     = 1'b1;
    tick_in = 1'b1;
    mode    = 2'd0;
    pause   = 1'b0;
    duty    = 8'hFF;
    repeat (3) @(negedge clk);
    tests++;
    if (led !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_led: got %h, required 00", led);
    end
    tests++;
    if (step_pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_step_pulse: got %b, required 0", step_pulse);
    end
    rst  = 1'b0;
    base = step_count;
    repeat (4) @(negedge clk);
    check_steps("reset_prime", step_count - base, 0);
    tests++;
    if (led !== 8'h01) begin
      fails++;
      $display("[TB] FAIL reset_pat: got %h, required 01", led);
    end
  endtask

  task automatic test_walk();
    int base;
    base = step_count;
    for (int i = 0; i < 9; i++) toggle_step(walk_exp[i], 1'b1, 10);
    drain("walk");
    check_steps("walk", step_count - base, 9);
  endtask

  task automatic test_ping_pong();
    int base;
    mode = 2'd1;
    do_reset();
    base = step_count;
    for (int i = 0; i < 16; i++) toggle_step(ping_exp[i], 1'b1, 4);
    drain("ping_pong");
    check_steps("ping_pong", step_count - base, 16);
  endtask

  task automatic test_count();
    int base;
    logic [N-1:0] e;
    mode = 2'd2;
    base = step_count;
    for (int i = 0; i < 257; i++) begin
      e = (i == 0) ? 8'h00 : 8'(i);
      toggle_step(e, 1'b1, 3);
    end
    drain("count");
    check_steps("count", step_count - base, 257);
  endtask

  task automatic test_blink_pause();
    int base;
    mode = 2'd3;
    toggle_step(8'hFF, 1'b1, 4);
    toggle_step(8'h00, 1'b1, 4);
    drain("blink");
    pause = 1'b1;
    base  = step_count;
    for (int i = 0; i < 3; i++) toggle_step(8'h00, 1'b0, 4);
    @(negedge clk);
    pause = 1'b0;
    repeat (5) @(negedge clk);
    check_steps("pause", step_count - base, 0);
    tests++;
    if (led !== 8'h00) begin
      fails++;
      $display("[TB] FAIL pause_led: got %h, required 00", led);
    end
    toggle_step(8'hFF, 1'b1, 4);
    drain("unpause");
    check_steps("unpause", step_count - base, 1);
  endtask

  task automatic test_pwm();
    int cnt [7];
    int exp_cnt [7] = '{64, 64, 192, 192, 0, 0, 256};
    int upper;
    foreach (cnt[k]) cnt[k] = 0;
    upper = 0;
    mode  = 2'd0;
    @(negedge clk);
    rst  = 1'b1;
    duty = 8'd64;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Window of 256 edges starting one edge after a duty load uses that duty
    for (int j = 1; j <= 1792; j++) begin
      @(negedge clk);
      if (led[0] === 1'b1) cnt[(j-1)/256]++;
      if (led[N-1:1] !== '0) upper++;
      if (j == 355)  duty = 8'd192;
      if (j == 768)  duty = 8'd0;
      if (j == 1280) duty = 8'd255;
    end
    for (int k = 0; k < 7; k++) begin
      tests++;
      if (cnt[k] != exp_cnt[k]) begin
        fails++;
        $display("[TB] FAIL pwm_period%0d_on: got %0d, required %0d", k, cnt[k], exp_cnt[k]);
      end
    end
    tests++;
    if (upper != 0) begin
      fails++;
      $display("[TB] FAIL pwm_upper_bits: got %0d lit cycles, required 0", upper);
    end
  endtask

  task automatic test_async_reset();
    int base;
    logic [N-1:0] e;
    mode = 2'd2;
    duty = 8'hFF;
    do_reset();
    for (int i = 0; i <= 8'h5A; i++) begin
      e = (i == 0) ? 8'h00 : 8'(i);
      toggle_step(e, 1'b1, 3);
    end
    drain("async_count");
    @(posedge clk);
    #1;
    tick_in = ~tick_in;
    @(posedge clk);
    #4;
    tests++;
    if (step_pulse !== 1'b1 || led !== 8'h5A) begin
      fails++;
      $display("[TB] FAIL async_pre: got pulse=%b led=%h, required pulse=1 led=5a", step_pulse, led);
    end
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (led !== 8'h00 || step_pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_immediate: got pulse=%b led=%h, required pulse=0 led=00", step_pulse, led);
    end
    tick_in = ~tick_in;
    mode    = 2'd0;
    #2;
    rst  = 1'b0;
    base = step_count;
    repeat (4) @(negedge clk);
    check_steps("async_prime", step_count - base, 0);
    tests++;
    if (led !== 8'h01) begin
      fails++;
      $display("[TB] FAIL async_pat: got %h, required 01", led);
    end
    toggle_step(8'h02, 1'b1, 4);
    drain("async_after");
    check_steps("async_after", step_count - base, 1);
  endtask

  initial begin
    test_reset();
    test_walk();
    test_ping_pong();
    test_count();
    test_blink_pause();
    test_pwm();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
